// File: rtl/mdu_param.sv
// Parametrised multi-cycle multiply/divide unit that owns the HI/LO registers.
// Optional multiply-accumulate ops (madd/maddu/msub/msubu) are enabled by defining MDU_PARAM_MACC_EN.
module mdu_param #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_PARAM_MACC_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [0:0] {IDLE, RUN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   pend_q, pend_d;
  logic                 pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  // Low 2*WIDTH bits of a product of extended operands equal the full-width product.
  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
  assign a_sx   = {{WIDTH{a[WIDTH-1]}}, a};
  assign b_sx   = {{WIDTH{b[WIDTH-1]}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // Divisor is forced to 1 in the special cases so the dividers never see 0 or overflow.
  logic               div_zero, div_ovf;
  logic [WIDTH-1:0]   b_safe_s, b_safe_u;
  logic signed [WIDTH-1:0] quot_s, rem_s;
  logic [WIDTH-1:0]   quot_u, rem_u;
  logic [2*WIDTH-1:0] div_s_res, div_u_res;

  assign div_zero  = (b == '0);
  assign div_ovf   = (a == MOST_NEG) && (b == '1);
  assign b_safe_s  = (div_zero || div_ovf) ? WIDTH'(1) : b;
  assign b_safe_u  = div_zero ? WIDTH'(1) : b;
  assign quot_s    = $signed(a) / $signed(b_safe_s);
  assign rem_s     = $signed(a) % $signed(b_safe_s);
  assign quot_u    = a / b_safe_u;
  assign rem_u     = a % b_safe_u;
  assign div_s_res = div_ovf ? {{WIDTH{1'b0}}, MOST_NEG} : {rem_s, quot_s};
  assign div_u_res = {rem_u, quot_u};

  logic last_cycle, can_accept;
  assign last_cycle = (state_q == RUN) && (cnt_q == CNT_W'(1));
  assign can_accept = !cancel && ((state_q == IDLE) || last_cycle);

`ifdef MDU_PARAM_MACC_EN
  // Accumulate base sees a result committing on this same edge.
  logic [2*WIDTH-1:0] acc_base, acc_addend, acc_res;
  logic               acc_sub;
  assign acc_base   = (last_cycle && !cancel && pend_valid_q) ? pend_q : {hi_q, lo_q};
  assign acc_addend = ((op == OP_MADD) || (op == OP_MSUB)) ? prod_s : prod_u;
  assign acc_sub    = (op == OP_MSUB) || (op == OP_MSUBU);
  assign acc_res    = acc_sub ? (acc_base - acc_addend) : (acc_base + acc_addend);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    hi_d         = hi_q;
    lo_d         = lo_q;

    if (state_q == RUN) begin
      if (cancel) begin
        state_d      = IDLE;
        cnt_d        = '0;
        pend_valid_d = 1'b0;
      end else if (last_cycle) begin
        if (pend_valid_q) begin
          {hi_d, lo_d} = pend_q;
        end
        state_d      = IDLE;
        cnt_d        = '0;
        pend_valid_d = 1'b0;
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end

    if (start && can_accept) begin
      case (op)
        OP_MULT, OP_MULTU: begin
          pend_d       = (op == OP_MULT) ? prod_s : prod_u;
          pend_valid_d = 1'b1;
          state_d      = RUN;
          cnt_d        = CNT_W'(MUL_LAT);
        end
        OP_DIV, OP_DIVU: begin
          pend_d       = (op == OP_DIV) ? div_s_res : div_u_res;
          pend_valid_d = !div_zero;
          state_d      = RUN;
          cnt_d        = CNT_W'(DIV_LAT);
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
`ifdef MDU_PARAM_MACC_EN
        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
          pend_d       = acc_res;
          pend_valid_d = 1'b1;
          state_d      = RUN;
          cnt_d        = CNT_W'(MUL_LAT);
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign hi   = hi_q;
  assign lo   = lo_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_mdu_param.sv
// Directed self-checking bench for mdu_param: a default 32-bit instance and a WIDTH=16, MUL_LAT=1, DIV_LAT=3 instance.
// Expectations for ops 7-10 follow whether MDU_PARAM_MACC_EN is defined.
module tb_mdu_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, cancel;
  logic [3:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy;

  logic        start16;
  logic [3:0]  op16;
  logic [15:0] a16, b16, hi16, lo16;
  logic        busy16;
  logic        cancel16;

  int n_compared   = 0;
  int n_mismatched = 0;
  int n_busy;

  always #5 clk = ~clk;

  mdu_param dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi(hi), .lo(lo), .busy(busy)
  );

  mdu_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(3)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .op(op16), .a(a16), .b(b16),
    .cancel(cancel16), .hi(hi16), .lo(lo16), .busy(busy16)
  );

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Presents one request for a single posedge; returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
  endtask

  task automatic applyStimulus16(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    start16 = 1'b1; op16 = o; a16 = x; b16 = y;
    @(negedge clk);
    start16 = 1'b0; op16 = 4'd0;
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic waitIdle16(output int n);
    n = 0;
    while (busy16 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; cancel = 1'b0; op = '0; a = '0; b = '0;
    start16 = 1'b0; op16 = '0; a16 = '0; b16 = '0; cancel16 = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_hi", 64'(hi), 64'h0);
    checkOutput("reset_lo", 64'(lo), 64'h0);
    checkOutput("reset_busy", 64'(busy), 64'h0);

    applyStimulus(4'd1, 32'hFFFF_FFFE, 32'd3);
    waitIdle(n_busy);
    checkOutput("mult_busy_cycles", 64'(n_busy), 64'd5);
    checkOutput("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("mult_lo", 64'(lo), 64'hFFFF_FFFA);

    applyStimulus(4'd2, 32'hFFFF_FFFE, 32'd3);
    waitIdle(n_busy);
    checkOutput("multu_hi", 64'(hi), 64'h2);
    checkOutput("multu_lo", 64'(lo), 64'hFFFF_FFFA);

    applyStimulus(4'd3, 32'hFFFF_FFF9, 32'd2);
    waitIdle(n_busy);
    checkOutput("div_busy_cycles", 64'(n_busy), 64'd10);
    checkOutput("div_lo", 64'(lo), 64'hFFFF_FFFD);
    checkOutput("div_hi", 64'(hi), 64'hFFFF_FFFF);

    applyStimulus(4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle(n_busy);
    checkOutput("div_ovf_lo", 64'(lo), 64'h8000_0000);
    checkOutput("div_ovf_hi", 64'(hi), 64'h0);

    applyStimulus(4'd5, 32'h1234_5678, 32'd0);
    checkOutput("mthi_hi", 64'(hi), 64'h1234_5678);
    checkOutput("mthi_busy", 64'(busy), 64'h0);
    checkOutput("mthi_lo_kept", 64'(lo), 64'h8000_0000);

    applyStimulus(4'd4, 32'd7, 32'd0);
    waitIdle(n_busy);
    checkOutput("divu0_busy_cycles", 64'(n_busy), 64'd10);
    checkOutput("divu0_hi", 64'(hi), 64'h1234_5678);
    checkOutput("divu0_lo", 64'(lo), 64'h8000_0000);

    // Second mult presented on busy cycles 1 and 2 must be dropped.
    applyStimulus(4'd1, 32'd4, 32'd5);
    start = 1'b1; op = 4'd1; a = 32'd100; b = 32'd100;
    repeat (2) @(negedge clk);
    start = 1'b0; op = 4'd0;
    waitIdle(n_busy);
    checkOutput("ignored_busy_cycles", 64'(n_busy), 64'd3);
    checkOutput("ignored_hi", 64'(hi), 64'h0);
    checkOutput("ignored_lo", 64'(lo), 64'd20);

    applyStimulus(4'd5, 32'h0000_AAAA, 32'd0);
    applyStimulus(4'd1, 32'd4, 32'd5);
    repeat (2) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_busy", 64'(busy), 64'h0);
    repeat (6) @(negedge clk);
    checkOutput("cancel_hi", 64'(hi), 64'h0000_AAAA);
    checkOutput("cancel_lo", 64'(lo), 64'd20);

    applyStimulus(4'd1, 32'd7, 32'd7);
    repeat (4) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    checkOutput("cancel_last_busy", 64'(busy), 64'h0);
    checkOutput("cancel_last_hi", 64'(hi), 64'h0000_AAAA);
    checkOutput("cancel_last_lo", 64'(lo), 64'd20);

    @(negedge clk);
    start = 1'b1; op = 4'd1; a = 32'd9; b = 32'd9; cancel = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0; cancel = 1'b0;
    checkOutput("cancel_idle_busy", 64'(busy), 64'h0);
    repeat (6) @(negedge clk);
    checkOutput("cancel_idle_lo", 64'(lo), 64'd20);

    applyStimulus(4'd12, 32'd3, 32'd3);
    checkOutput("undef_op_busy", 64'(busy), 64'h0);
    applyStimulus(4'd0, 32'd3, 32'd3);
    repeat (6) @(negedge clk);
    checkOutput("undef_op_hi", 64'(hi), 64'h0000_AAAA);
    checkOutput("undef_op_lo", 64'(lo), 64'd20);

    applyStimulus(4'd3, 32'd100, 32'd7);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checkOutput("reset_mid_hi", 64'(hi), 64'h0);
    checkOutput("reset_mid_lo", 64'(lo), 64'h0);
    checkOutput("reset_mid_busy", 64'(busy), 64'h0);
    repeat (12) @(negedge clk);
    checkOutput("reset_mid_lo_late", 64'(lo), 64'h0);

`ifdef MDU_PARAM_MACC_EN
    applyStimulus(4'd6, 32'hFFFF_FFFF, 32'd0);
    applyStimulus(4'd8, 32'd1, 32'd1);
    waitIdle(n_busy);
    checkOutput("maddu_busy_cycles", 64'(n_busy), 64'd5);
    checkOutput("maddu_hi", 64'(hi), 64'h1);
    checkOutput("maddu_lo", 64'(lo), 64'h0);
    applyStimulus(4'd5, 32'd0, 32'd0);
    applyStimulus(4'd9, 32'd2, 32'd3);
    waitIdle(n_busy);
    checkOutput("msub_hi", 64'(hi), 64'hFFFF_FFFF);
    checkOutput("msub_lo", 64'(lo), 64'hFFFF_FFFA);
`else
    applyStimulus(4'd6, 32'h0000_0055, 32'd0);
    applyStimulus(4'd7, 32'd1, 32'd1);
    checkOutput("madd_off_busy", 64'(busy), 64'h0);
    repeat (6) @(negedge clk);
    checkOutput("madd_off_hi", 64'(hi), 64'h0);
    checkOutput("madd_off_lo", 64'(lo), 64'h55);
`endif

    applyStimulus16(4'd2, 16'hFFFF, 16'hFFFF);
    checkOutput("w16_multu_busy", 64'(busy16), 64'h1);
    waitIdle16(n_busy);
    checkOutput("w16_multu_cycles", 64'(n_busy), 64'd1);
    checkOutput("w16_multu_hi", 64'(hi16), 64'hFFFE);
    checkOutput("w16_multu_lo", 64'(lo16), 64'h0001);

    // Second divu held from busy cycle 1 on; it is taken on the completing edge of the first.
    applyStimulus16(4'd4, 16'd100, 16'd7);
    start16 = 1'b1; op16 = 4'd4; a16 = 16'd50; b16 = 16'd7;
    repeat (3) @(negedge clk);
    start16 = 1'b0; op16 = 4'd0;
    checkOutput("w16_b2b_busy", 64'(busy16), 64'h1);
    checkOutput("w16_b2b_first_lo", 64'(lo16), 64'h000E);
    checkOutput("w16_b2b_first_hi", 64'(hi16), 64'h0002);
    waitIdle16(n_busy);
    checkOutput("w16_b2b_cycles", 64'(n_busy), 64'd3);
    checkOutput("w16_b2b_second_lo", 64'(lo16), 64'h0007);
    checkOutput("w16_b2b_second_hi", 64'(hi16), 64'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
